// File: rtl/fpu_div_param.sv
// Parameterised IEEE-754 divider: radix-2 restoring, one quotient bit per cycle, STB/BUSY handshake.
// Define FPU_DIV_DENORM_EN for subnormal operands/results; otherwise subnormals flush to signed zero.
module fpu_div_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   input_a,
  input  logic [EXP_W+MAN_W:0]   input_b,
  input  logic [1:0]             div_rm,
  input  logic                   div_input_STB,
  output logic                   div_BUSY,
  output logic [EXP_W+MAN_W:0]   output_div,
  output logic [4:0]             div_flags,
  output logic                   div_output_STB,
  input  logic                   output_module_BUSY
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int N    = MAN_W + 4;
  localparam int EW   = EXP_W + 3;
  localparam int CW   = 7;
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] EMAX_B = EW'(2**EXP_W - 2);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b1, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_UNPACK, S_SPECIAL, S_NORM_A, S_NORM_B,
    S_DIVIDE, S_NORM_Z, S_ROUND, S_PACK, S_PUT_Z
  } state_t;
  typedef enum logic [1:0] {RM_RNE, RM_RTZ, RM_RUP, RM_RDN} rm_t;

  state_t               state_q, state_d;
  rm_t                  rm_q, rm_d;
  logic [W-1:0]         a_q, a_d, b_q, b_d, z_q, z_d;
  logic signed [EW-1:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic [MAN_W:0]       a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic [N-1:0]         q_q, q_d;
  logic [MAN_W+1:0]     rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [4:0]           flags_q, flags_d;
  logic                 sticky_q, sticky_d, nz_first_q, nz_first_d;
  logic                 inexact_q, inexact_d, tiny_q, tiny_d;
  logic                 busy_q, busy_d, ostb_q, ostb_d;

  // Operand classification straight from the latched encodings.
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, z_sign;
  assign a_exp  = a_q[W-2:MAN_W];
  assign b_exp  = b_q[W-2:MAN_W];
  assign a_man  = a_q[MAN_W-1:0];
  assign b_man  = b_q[MAN_W-1:0];
  assign a_nan  = (&a_exp) & (|a_man);
  assign b_nan  = (&b_exp) & (|b_man);
  assign a_snan = a_nan & ~a_man[MAN_W-1];
  assign b_snan = b_nan & ~b_man[MAN_W-1];
  assign a_inf  = (&a_exp) & ~(|a_man);
  assign b_inf  = (&b_exp) & ~(|b_man);
`ifdef FPU_DIV_DENORM_EN
  assign a_zero = ~(|a_exp) & ~(|a_man);
  assign b_zero = ~(|b_exp) & ~(|b_man);
`else
  assign a_zero = ~(|a_exp);
  assign b_zero = ~(|b_exp);
`endif
  assign z_sign = a_q[W-1] ^ b_q[W-1];

  // Restoring step, quotient alignment and rounding datapath.
  logic [MAN_W+1:0]     b_ext, rem_diff, mant_r;
  logic                 rem_ge, rnd_g, rnd_r, rnd_s, round_up, ovf, ovf_to_inf;
  logic [N-1:0]         q_al;
  logic signed [EW-1:0] e_al, biased;
  assign b_ext    = {1'b0, b_m_q};
  assign rem_ge   = rem_q >= b_ext;
  assign rem_diff = rem_ge ? rem_q - b_ext : rem_q;
  assign q_al     = (nz_first_q && !q_q[N-1]) ? {q_q[N-2:0], 1'b0} : q_q;
  assign e_al     = (nz_first_q && !q_q[N-1]) ? z_e_q - ONE_E : z_e_q;
  assign rnd_g    = q_q[2];
  assign rnd_r    = q_q[1];
  assign rnd_s    = q_q[0] | sticky_q;
  assign mant_r   = {1'b0, q_q[N-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
  assign biased   = z_e_q + BIAS_E;
  assign ovf      = biased > EMAX_B;
  assign ovf_to_inf = (rm_q == RM_RNE) | ((rm_q == RM_RUP) & ~z_sign) | ((rm_q == RM_RDN) & z_sign);

  always_comb begin
    unique case (rm_q)
      RM_RNE:  round_up = rnd_g & (rnd_r | rnd_s | q_q[3]);
      RM_RUP:  round_up = ~z_sign & (rnd_g | rnd_r | rnd_s);
      RM_RDN:  round_up = z_sign & (rnd_g | rnd_r | rnd_s);
      default: round_up = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no branch can leave a latch behind.
    state_d = state_q;  rm_d = rm_q;        a_d = a_q;          b_d = b_q;
    z_d = z_q;          a_e_d = a_e_q;      b_e_d = b_e_q;      z_e_d = z_e_q;
    a_m_d = a_m_q;      b_m_d = b_m_q;      z_m_d = z_m_q;      q_d = q_q;
    rem_d = rem_q;      cnt_d = cnt_q;      flags_d = flags_q;  sticky_d = sticky_q;
    nz_first_d = nz_first_q; inexact_d = inexact_q; tiny_d = tiny_q;
    busy_d = busy_q;    ostb_d = ostb_q;
    unique case (state_q)
      S_IDLE: if (div_input_STB && !busy_q) begin
        a_d = input_a;  b_d = input_b;  rm_d = rm_t'(div_rm);
        busy_d = 1'b1;  state_d = S_UNPACK;
      end
      S_UNPACK: begin
        a_e_d = $signed({3'b000, a_exp}) - BIAS_E;
        b_e_d = $signed({3'b000, b_exp}) - BIAS_E;
        a_m_d = {1'b0, a_man};
        b_m_d = {1'b0, b_man};
        state_d = S_SPECIAL;
      end
      S_SPECIAL: begin
        state_d = S_PUT_Z;
        ostb_d  = 1'b1;
        if (a_nan || b_nan) begin
          z_d = QNAN;  flags_d = {a_snan | b_snan, 4'b0000};
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
          z_d = QNAN;  flags_d = 5'b10000;
        end else if (a_inf) begin
          z_d = {z_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  flags_d = 5'b00000;
        end else if (b_inf || a_zero) begin
          z_d = {z_sign, {(W-1){1'b0}}};  flags_d = 5'b00000;
        end else if (b_zero) begin
          z_d = {z_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};  flags_d = 5'b01000;
        end else begin
          state_d = S_NORM_A;
          ostb_d  = 1'b0;
          if (~(|a_exp)) a_e_d = EMIN_E; else a_m_d[MAN_W] = 1'b1;
          if (~(|b_exp)) b_e_d = EMIN_E; else b_m_d[MAN_W] = 1'b1;
        end
      end
      S_NORM_A: begin
`ifdef FPU_DIV_DENORM_EN
        if (!a_m_q[MAN_W]) begin
          a_m_d = {a_m_q[MAN_W-1:0], 1'b0};
          a_e_d = a_e_q - ONE_E;
        end else state_d = S_NORM_B;
`else
        state_d = S_NORM_B;
`endif
      end
      S_NORM_B: begin
`ifdef FPU_DIV_DENORM_EN
        if (!b_m_q[MAN_W]) begin
          b_m_d = {b_m_q[MAN_W-1:0], 1'b0};
          b_e_d = b_e_q - ONE_E;
        end else
`endif
        begin
          rem_d = {1'b0, a_m_q};
          q_d   = '0;
          cnt_d = '0;
          z_e_d = a_e_q - b_e_q;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        rem_d = {rem_diff[MAN_W:0], 1'b0};
        q_d   = {q_q[N-2:0], rem_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          sticky_d   = |rem_diff;
          nz_first_d = 1'b1;
          state_d    = S_NORM_Z;
        end
      end
      S_NORM_Z: begin
        nz_first_d = 1'b0;
        q_d   = q_al;
        z_e_d = e_al;
        state_d = S_ROUND;
`ifdef FPU_DIV_DENORM_EN
        // Below the normal range: shift right, keeping lost bits in sticky.
        if (e_al < EMIN_E) begin
          q_d      = {1'b0, q_al[N-1:1]};
          sticky_d = sticky_q | q_al[0];
          z_e_d    = e_al + ONE_E;
          state_d  = S_NORM_Z;
        end
`endif
      end
      S_ROUND: begin
        inexact_d = rnd_g | rnd_r | rnd_s;
        tiny_d    = ~q_q[N-1];
        if (mant_r[MAN_W+1]) begin
          z_m_d = mant_r[MAN_W+1:1];
          z_e_d = z_e_q + ONE_E;
        end else z_m_d = mant_r[MAN_W:0];
        state_d = S_PACK;
      end
      S_PACK: begin
        state_d = S_PUT_Z;
        ostb_d  = 1'b1;
        z_d     = {z_sign, z_m_q[MAN_W] ? biased[EXP_W-1:0] : {EXP_W{1'b0}}, z_m_q[MAN_W-1:0]};
        flags_d = {3'b000, tiny_q & inexact_q, inexact_q};
        if (ovf) begin
          z_d = ovf_to_inf ? {z_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                           : {z_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
          flags_d = 5'b00101;
        end
`ifndef FPU_DIV_DENORM_EN
        else if (biased < ONE_E) begin
          z_d     = {z_sign, {(W-1){1'b0}}};
          flags_d = 5'b00011;
        end
`endif
      end
      S_PUT_Z: if (ostb_q && !output_module_BUSY) begin
        ostb_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers take <= so every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;  rm_q <= RM_RNE;   a_q <= '0;      b_q <= '0;      z_q <= '0;
      a_e_q <= '0;        b_e_q <= '0;      z_e_q <= '0;    a_m_q <= '0;    b_m_q <= '0;
      z_m_q <= '0;        q_q <= '0;        rem_q <= '0;    cnt_q <= '0;    flags_q <= '0;
      sticky_q <= 1'b0;   nz_first_q <= 1'b0; inexact_q <= 1'b0; tiny_q <= 1'b0;
      busy_q <= 1'b0;     ostb_q <= 1'b0;
    end else begin
      state_q <= state_d; rm_q <= rm_d;     a_q <= a_d;     b_q <= b_d;     z_q <= z_d;
      a_e_q <= a_e_d;     b_e_q <= b_e_d;   z_e_q <= z_e_d; a_m_q <= a_m_d; b_m_q <= b_m_d;
      z_m_q <= z_m_d;     q_q <= q_d;       rem_q <= rem_d; cnt_q <= cnt_d; flags_q <= flags_d;
      sticky_q <= sticky_d; nz_first_q <= nz_first_d; inexact_q <= inexact_d; tiny_q <= tiny_d;
      busy_q <= busy_d;   ostb_q <= ostb_d;
    end
  end

  assign div_BUSY       = busy_q;
  assign div_output_STB = ostb_q;
  assign output_div     = z_q;
  assign div_flags      = flags_q;
endmodule

// File: tb/tb_fpu_div_param.sv
// Bench for fpu_div_param: directed single/half cases plus random single-precision
// transactions compared against an exact-rational rounding model.
module tb_fpu_div_param;
`ifdef FPU_DIV_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif
  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] sp_a, sp_b, sp_z;
  logic [1:0]  sp_rm;
  logic [4:0]  sp_flags;
  logic        sp_stb, sp_busy, sp_ostb, sp_obusy;
  logic [15:0] hp_a, hp_b, hp_z;
  logic [1:0]  hp_rm;
  logic [4:0]  hp_flags;
  logic        hp_stb, hp_busy, hp_ostb, hp_obusy;

  fpu_div_param #(.EXP_W(8), .MAN_W(23)) u_sp (
    .clk(clk), .rst(rst), .input_a(sp_a), .input_b(sp_b), .div_rm(sp_rm),
    .div_input_STB(sp_stb), .div_BUSY(sp_busy), .output_div(sp_z), .div_flags(sp_flags),
    .div_output_STB(sp_ostb), .output_module_BUSY(sp_obusy));

  fpu_div_param #(.EXP_W(5), .MAN_W(10)) u_hp (
    .clk(clk), .rst(rst), .input_a(hp_a), .input_b(hp_b), .div_rm(hp_rm),
    .div_input_STB(hp_stb), .div_BUSY(hp_busy), .output_div(hp_z), .div_flags(hp_flags),
    .div_output_STB(hp_ostb), .output_module_BUSY(hp_obusy));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one transaction and wait (bounded) for its result strobe.
  task automatic run_sp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                        output logic [31:0] z, output logic [4:0] f, output int lat);
    sp_a = a; sp_b = b; sp_rm = rm; sp_stb = 1'b1;
    @(posedge clk); #1 sp_stb = 1'b0;
    check("busy_on_accept", sp_busy, 1'b1);
    lat = 0;
    do begin @(posedge clk); #1 lat++; end while (!sp_ostb && lat < LIMIT);
    check("stb_seen", sp_ostb, 1'b1);
    z = sp_z; f = sp_flags;
  endtask

  task automatic finish_sp();
    sp_obusy = 1'b0;
    @(posedge clk); #1;
    check("handshake_idle", {sp_ostb, sp_busy}, 2'b00);
  endtask

  // Exact model: significand quotient as a wide integer, then IEEE rounding by value.
  function automatic logic [36:0] model_sp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] rm);
    logic s, sticky, half, rest, inexact, up, tiny;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic [127:0] ma, mb, num, q, kept;
    int ea, eb, xa, xb, e2, m, e_q, lsb, sh, biased;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_snan = a_nan && !a[22];
    b_snan = b_nan && !b[22];
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0) && (!DENORM || a[22:0] == 0);
    b_zero = (eb == 0) && (!DENORM || b[22:0] == 0);
    if (a_nan || b_nan) return {(a_snan || b_snan) ? 5'b10000 : 5'b00000, 32'hFFC0_0000};
    if ((a_inf && b_inf) || (a_zero && b_zero)) return {5'b10000, 32'hFFC0_0000};
    if (a_inf) return {5'b00000, s, 31'h7F80_0000};
    if (b_inf || a_zero) return {5'b00000, s, 31'h0};
    if (b_zero) return {5'b01000, s, 31'h7F80_0000};
    ma = (ea == 0) ? {105'd0, a[22:0]} : {104'd0, 1'b1, a[22:0]};
    mb = (eb == 0) ? {105'd0, b[22:0]} : {104'd0, 1'b1, b[22:0]};
    xa = ((ea == 0) ? 1 : ea) - 150;
    xb = ((eb == 0) ? 1 : eb) - 150;
    num = ma << 64;
    q = num / mb;
    sticky = (num % mb) != 0;
    e2 = xa - xb - 64;
    m = 0;
    for (int i = 0; i < 128; i++) if (q[i]) m = i;
    e_q  = m + e2;
    tiny = DENORM && (e_q < -126);
    lsb  = (DENORM && e_q < -126) ? -149 : e_q - 23;
    sh   = lsb - e2;
    if (sh > 120) begin
      kept = '0; half = 1'b0; rest = 1'b1;
    end else begin
      kept = q >> sh;
      half = q[sh-1];
      rest = sticky || ((q & ((128'd1 << (sh - 1)) - 128'd1)) != 0);
    end
    inexact = half || rest;
    case (rm)
      2'd0:    up = half && (rest || kept[0]);
      2'd2:    up = !s && inexact;
      2'd3:    up = s && inexact;
      default: up = 1'b0;
    endcase
    kept = kept + {127'd0, up};
    if (kept >= 128'h100_0000) begin kept = kept >> 1; lsb++; end
    biased = (kept >= 128'h80_0000) ? lsb + 150 : 0;
    if (biased > 254) begin
      if (rm == 2'd0 || (rm == 2'd2 && !s) || (rm == 2'd3 && s)) return {5'b00101, s, 31'h7F80_0000};
      return {5'b00101, s, 31'h7F7F_FFFF};
    end
    if (!DENORM && biased < 1) return {5'b00011, s, 31'h0};
    return {3'b000, tiny && inexact, inexact, s, 8'(biased), kept[22:0]};
  endfunction

  function automatic logic [31:0] rand_sp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 19);
    if (k < 12)       v[30:23] = 8'(127 + $urandom_range(0, 60) - 30);
    else if (k == 15) v[30:0]  = '0;
    else if (k == 16) v[30:0]  = 31'h7F80_0000;
    else if (k == 17) v[30:23] = 8'h00;
    else if (k == 18) v[30:23] = 8'hFF;
    else if (k == 19) v[30:23] = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 12))
                                                             : 8'($urandom_range(243, 254));
    return v;
  endfunction

  logic [31:0] z;
  logic [4:0]  f;
  logic [36:0] exp_zf;
  int lat;

  initial begin
    rst = 1'b0;
    sp_a = '0; sp_b = '0; sp_rm = '0; sp_stb = 1'b0; sp_obusy = 1'b0;
    hp_a = '0; hp_b = '0; hp_rm = '0; hp_stb = 1'b0; hp_obusy = 1'b0;
    #2;
    check("reset_busy", sp_busy, 1'b0);
    check("reset_stb", sp_ostb, 1'b0);
    check("reset_z", sp_z, 32'h0);
    check("reset_flags", sp_flags, 5'b0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    run_sp(32'h3F80_0000, 32'h4040_0000, 2'd0, z, f, lat);
    check("third_rne_z", z, 32'h3EAA_AAAB);
    check("third_rne_f", f, 5'b00001);
    finish_sp();
    run_sp(32'h3F80_0000, 32'h4040_0000, 2'd1, z, f, lat);
    check("third_rtz_z", z, 32'h3EAA_AAAA);
    check("third_rtz_f", f, 5'b00001);
    finish_sp();

    sp_obusy = 1'b1;
    run_sp(32'h40C0_0000, 32'h4000_0000, 2'd0, z, f, lat);
    check("six_half_z", z, 32'h4040_0000);
    check("six_half_f", f, 5'b00000);
    check("six_half_lat", lat, 34);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_stable", {sp_ostb, sp_busy, sp_flags, sp_z}, {1'b1, 1'b1, 5'b00000, 32'h4040_0000});
    end
    finish_sp();

    run_sp(32'h3F80_0000, 32'h0000_0000, 2'd0, z, f, lat);
    check("div0_z", z, 32'h7F80_0000);
    check("div0_f", f, 5'b01000);
    finish_sp();
    run_sp(32'h0000_0000, 32'h0000_0000, 2'd0, z, f, lat);
    check("zz_z", z, 32'hFFC0_0000);
    check("zz_f", f, 5'b10000);
    check("zz_lat", lat, 2);
    finish_sp();
    run_sp(32'h7F80_0001, 32'h3F80_0000, 2'd0, z, f, lat);
    check("snan_z", z, 32'hFFC0_0000);
    check("snan_f", f, 5'b10000);
    finish_sp();

    run_sp(32'h7F7F_FFFF, 32'h3F00_0000, 2'd0, z, f, lat);
    check("ovf_rne_z", z, 32'h7F80_0000);
    check("ovf_rne_f", f, 5'b00101);
    finish_sp();
    run_sp(32'h7F7F_FFFF, 32'h3F00_0000, 2'd1, z, f, lat);
    check("ovf_rtz_z", z, 32'h7F7F_FFFF);
    check("ovf_rtz_f", f, 5'b00101);
    finish_sp();
    run_sp(32'hFF7F_FFFF, 32'h3F00_0000, 2'd3, z, f, lat);
    check("ovf_rdn_z", z, 32'hFF80_0000);
    finish_sp();

    run_sp(32'h0080_0000, 32'h4000_0000, 2'd0, z, f, lat);
    check("sub_z", z, DENORM ? 32'h0040_0000 : 32'h0000_0000);
    check("sub_f", f, DENORM ? 5'b00000 : 5'b00011);
    finish_sp();

    hp_a = 16'h3C00; hp_b = 16'h4200; hp_rm = 2'd0; hp_stb = 1'b1;
    @(posedge clk); #1 hp_stb = 1'b0;
    lat = 0;
    do begin @(posedge clk); #1 lat++; end while (!hp_ostb && lat < LIMIT);
    check("half_z", hp_z, 16'h3555);
    check("half_f", hp_flags, 5'b00001);
    check("half_lat", lat, 21);
    @(posedge clk); #1;
    check("half_idle", {hp_ostb, hp_busy}, 2'b00);

    sp_a = 32'h40C0_0000; sp_b = 32'h4000_0000; sp_rm = 2'd0; sp_stb = 1'b1;
    @(posedge clk); #1 sp_stb = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b0;
    #1 check("midreset_idle", {sp_ostb, sp_busy}, 2'b00);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("midreset_quiet", sp_ostb, 1'b0);
    run_sp(32'h4110_0000, 32'h4040_0000, 2'd0, z, f, lat);
    check("post_reset_z", z, 32'h4040_0000);
    check("post_reset_f", f, 5'b00000);
    finish_sp();

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rrm;
      ra = rand_sp();
      rb = rand_sp();
      rrm = 2'($urandom_range(0, 3));
      exp_zf = model_sp(ra, rb, rrm);
      run_sp(ra, rb, rrm, z, f, lat);
      check($sformatf("rnd%0d_z %h/%h rm%0d", i, ra, rb, rrm), z, exp_zf[31:0]);
      check($sformatf("rnd%0d_f %h/%h rm%0d", i, ra, rb, rrm), f, exp_zf[36:32]);
      finish_sp();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_div_param.md
# fpu_div_param

- Parametrised IEEE-754 floating-point divider; successor to the fixed single-precision divider.
- Generalised in exponent and mantissa width (half, single, double).
- Adds four per-transaction rounding modes and per-result exception flags.
- Sits between an operand source and a result consumer on the team's STB/BUSY handshake; one radix-2 restoring quotient bit per cycle.

## Interface
- EXP_W, 8, exponent width (5..11)
- MAN_W, 23, stored mantissa width (10..52); W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1
- clk  input  1  sole clock, rising edge
- rst  input  1  reset; asynchronous, active-low
- input_a  input  W  dividend operand
- input_b  input  W  divisor operand
- div_rm  input  2  rounding mode, sampled with operands: 0 RNE, 1 RTZ, 2 RUP (+inf), 3 RDN (-inf)
- div_input_STB  input  1  operands valid
- div_BUSY  output  1  divider holds a transaction; no acceptance
- output_div  output  W  quotient
- div_flags  output  5  {invalid, div_by_zero, overflow, underflow, inexact} for output_div
- div_output_STB  output  1  output_div/div_flags valid
- output_module_BUSY  input  1  consumer cannot take result

## Operation
- States: IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIVIDE, NORM_Z, ROUND, PACK, PUT_Z.
- **IDLE**
  - Acceptance occurs when div_input_STB=1 and div_BUSY=0.
  - On acceptance: latch a, b, div_rm; div_BUSY<=1; go to UNPACK.
- **UNPACK**
  - Split sign, exponent and mantissa.
  - Internal exponent is signed EXP_W+3 bits, unbiased.
- **SPECIAL**: evaluated in priority order; matching cases write z and flags, then go to PUT_Z.
  - Either input NaN -> canonical qNaN (sign 1, exponent all ones, mantissa MSB 1, rest 0). Invalid is set only if an input is sNaN (mantissa MSB 0, nonzero).
  - inf/inf or 0/0 -> qNaN, invalid.
  - inf/finite -> signed inf, no flags.
  - finite/inf -> signed zero.
  - 0/nonzero -> signed zero.
  - nonzero finite/0 -> signed inf, div_by_zero.
  - Otherwise: set hidden bit (subnormal: exponent 1-BIAS), go to NORM_A.
- **NORM_A / NORM_B**
  - Shift mantissa left one bit per cycle until the hidden bit is set, decrementing the exponent.
  - An already-normal operand takes 1 cycle.
- **DIVIDE**
  - N = MAN_W+4 iterations, one quotient bit each.
  - Sticky = OR of the final remainder.
  - z_e = a_e - b_e.
- **NORM_Z**
  - Quotient lies in [0.5, 2): one left-align step (exponent decrement) when the MSB is 0.
  - Then right-shift one bit per cycle while z_e < 1-BIAS, folding shifted-out bits into sticky.
- **ROUND**
  - Apply div_rm using guard/round/sticky.
  - Mantissa carry-out increments the exponent.
  - inexact = guard|round|sticky.
- **PACK**
  - Biased exponent above max -> overflow + inexact. Result per mode:
    - RNE -> inf.
    - RTZ -> max finite.
    - RUP -> +inf if positive, else -max.
    - RDN -> -inf if negative, else +max.
  - Result tiny before rounding and inexact -> underflow.
- **PUT_Z**
  - Hold div_output_STB=1 with output_div and div_flags stable while output_module_BUSY=1.
  - On an edge with div_output_STB=1 and output_module_BUSY=0: STB<=0, div_BUSY<=0, go to IDLE.
- div_flags reflect the current result only; they do not accumulate.

## Timing
- Reset (rst=0, asynchronous): state IDLE, div_BUSY=0, div_output_STB=0, output_div=0, div_flags=0.
- Reset mid-operation: discards the transaction immediately. No output STB is produced for it.
- div_BUSY rises on the acceptance edge and falls on the output handshake edge. The next acceptance is no earlier than the following edge.
- output_div, div_flags and div_output_STB are updated on the edge entering PUT_Z.
- **Latency**, counted as edges after acceptance until div_output_STB=1:
  - SPECIAL result: 2 edges.
  - Normal operands with normal result: N+7 edges (34 for single, 21 for half).
  - Each subnormal normalise or denormalise shift adds 1 edge.
- div_input_STB asserted while div_BUSY=1 is ignored; the source holds its data.
- div_output_STB never drops without a handshake.

## Configuration
- FPU_DIV_DENORM_EN defined:
  - Subnormal inputs are normalised.
  - Subnormal outputs are produced via the NORM_Z right shift.
- FPU_DIV_DENORM_EN undefined:
  - Subnormal inputs are treated as signed zero.
  - Results with biased exponent below 1 flush to signed zero with underflow+inexact.
  - NORM_A/NORM_B/NORM_Z take a fixed 1 cycle each.

## Test plan
- Single, 0x3F800000 / 0x40400000:
  - RNE -> 0x3EAAAAAB, flags 00001.
  - RTZ -> 0x3EAAAAAA, flags 00001.
- 0x40C00000 / 0x40000000 RNE -> 0x40400000, flags 0. STB exactly 34 edges after acceptance. Holding output_module_BUSY=1 for 10 cycles keeps the result stable and div_BUSY=1.
- Special cases:
  - 0x3F800000 / 0 -> 0x7F800000, div_by_zero.
  - 0 / 0 -> 0xFFC00000, invalid; STB 2 edges after acceptance.
  - 0x7F800001 / 1.0 -> 0xFFC00000, invalid.
- Overflow, 0x7F7FFFFF / 0x3F000000:
  - RNE -> 0x7F800000, flags 00101.
  - RTZ -> 0x7F7FFFFF, flags 00101.
  - RDN with a negated -> 0xFF800000.
- Subnormal, 0x00800000 / 0x40000000:
  - FPU_DIV_DENORM_EN defined -> 0x00400000, flags 0.
  - Undefined -> 0x00000000, flags 00011.
- Half precision (EXP_W=5, MAN_W=10): 0x3C00 / 0x4200 RNE -> 0x3555, inexact.
- Reset: rst pulsed low mid-DIVIDE -> STB=0 and BUSY=0 immediately, and the next transaction is correct.
